// File: rtl/mem_stage_sram_ctrl.sv
// Memory stage of the 5-stage ARM pipeline: maps the EX/MEM ALU result onto a
// fixed-latency single-port SRAM and freezes earlier stages until the access ends.
module mem_stage_sram_ctrl #(
  parameter int          WAIT_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ALU_res_in,
  input  logic [31:0]       Val_Rm_in,
  input  logic              MEM_R_EN_in,
  input  logic              MEM_W_EN_in,
  input  logic              WB_EN_in,
  input  logic [3:0]        Dest_in,
  output logic              freeze,
  output logic [31:0]       mem_data_out,
  output logic [31:0]       ALU_res_out,
  output logic              WB_EN_out,
  output logic              MEM_R_EN_out,
  output logic [3:0]        Dest_out,
  output logic              addr_err,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic        is_write;
  logic        req, wr_req, rd_req, in_range, last_cycle;
  logic [31:0] off;

  // A simultaneous read and write request is treated as a write.
  assign wr_req     = MEM_W_EN_in;
  assign rd_req     = MEM_R_EN_in & ~MEM_W_EN_in;
  assign req        = MEM_R_EN_in | MEM_W_EN_in;
  assign off        = ALU_res_in - BASE_ADDR;
  assign in_range   = (ALU_res_in >= BASE_ADDR) && ((off >> (ADDR_W + 2)) == 32'd0);
  assign last_cycle = (cnt == LAST_CNT);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = in_range ? ACCESS : DONE;
      ACCESS:  if (last_cycle) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      is_write     <= 1'b0;
      mem_data_out <= 32'd0;
      addr_err     <= 1'b0;
    end else begin
      state    <= next_state;
      addr_err <= (state == IDLE) && req && !in_range;
      case (state)
        IDLE: begin
          if (req) begin
            cnt      <= 4'd0;
            is_write <= wr_req;
            if (!in_range && rd_req) mem_data_out <= 32'd0;
          end
        end
        ACCESS: begin
          cnt <= cnt + 4'd1;
          if (last_cycle && !is_write) mem_data_out <= sram_rdata;
        end
        default: ;
      endcase
    end
  end

  // Freeze must drop as soon as reset asserts, even with a request still present.
  assign freeze = rst & (((state == IDLE) & req) | (state == ACCESS));

  assign sram_addr  = off[ADDR_W+1:2];
  assign sram_wdata = Val_Rm_in;
  assign sram_we_n  = !((state == ACCESS) && is_write);
  assign sram_oe_n  = !((state == ACCESS) && !is_write);

  assign ALU_res_out  = ALU_res_in;
  assign WB_EN_out    = WB_EN_in;
  assign MEM_R_EN_out = MEM_R_EN_in;
  assign Dest_out     = Dest_in;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl: table of single transactions on a
// WAIT_CYCLES=4 instance plus hand-written multi-cycle sequences.
module tb_mem_stage_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu, val, rdata;
  logic        r_en, w_en, wb_en;
  logic [3:0]  dest;

  logic        f4, err4, wb4, ren4, we4, oe4;
  logic [31:0] mem4, alu4, wdata4;
  logic [3:0]  dest4;
  logic [15:0] addr4;

  logic        f1, err1, wb1, ren1, we1, oe1;
  logic [31:0] mem1, alu1, wdata1;
  logic [3:0]  dest1;
  logic [15:0] addr1;

  logic        use_one;
  logic        s_freeze, s_we_n, s_oe_n, s_err;
  logic [15:0] s_addr;
  logic [31:0] s_wdata, s_mem;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_sram_ctrl #(.WAIT_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .ALU_res_in(alu), .Val_Rm_in(val),
    .MEM_R_EN_in(r_en), .MEM_W_EN_in(w_en), .WB_EN_in(wb_en), .Dest_in(dest),
    .freeze(f4), .mem_data_out(mem4), .ALU_res_out(alu4), .WB_EN_out(wb4),
    .MEM_R_EN_out(ren4), .Dest_out(dest4), .addr_err(err4), .sram_addr(addr4),
    .sram_wdata(wdata4), .sram_rdata(rdata), .sram_we_n(we4), .sram_oe_n(oe4)
  );

  mem_stage_sram_ctrl #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .ALU_res_in(alu), .Val_Rm_in(val),
    .MEM_R_EN_in(r_en), .MEM_W_EN_in(w_en), .WB_EN_in(wb_en), .Dest_in(dest),
    .freeze(f1), .mem_data_out(mem1), .ALU_res_out(alu1), .WB_EN_out(wb1),
    .MEM_R_EN_out(ren1), .Dest_out(dest1), .addr_err(err1), .sram_addr(addr1),
    .sram_wdata(wdata1), .sram_rdata(rdata), .sram_we_n(we1), .sram_oe_n(oe1)
  );

  assign s_freeze = use_one ? f1     : f4;
  assign s_we_n   = use_one ? we1    : we4;
  assign s_oe_n   = use_one ? oe1    : oe4;
  assign s_err    = use_one ? err1   : err4;
  assign s_addr   = use_one ? addr1  : addr4;
  assign s_wdata  = use_one ? wdata1 : wdata4;
  assign s_mem    = use_one ? mem1   : mem4;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] val;
    logic [31:0] rdata;
    logic        r;
    logic        w;
    logic [3:0]  dest;
    int          fz;
    int          we;
    int          oe;
    int          err;
    logic [15:0] addr;
    logic [31:0] mem;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    alu   = v.alu;
    val   = v.val;
    rdata = v.rdata;
    r_en  = v.r;
    w_en  = v.w;
    wb_en = v.r;
    dest  = v.dest;
    #1;
  endtask

  // Samples once per cycle until freeze drops; returns positioned in the DONE cycle.
  task automatic measure(output int fz, output int we, output int oe, output int err,
                         output logic [15:0] a, output logic [31:0] wd);
    int n;
    n = 0; fz = 0; we = 0; oe = 0; err = 0; a = '0; wd = '0;
    while (s_freeze && n < 40) begin
      fz++;
      if (!s_we_n) begin we++; a = s_addr; wd = s_wdata; end
      if (!s_oe_n) begin oe++; a = s_addr; end
      if (s_err) err++;
      @(negedge clk); #1;
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("[TB] FAIL freeze_timeout: got freeze stuck high expected release within 40 cycles");
    end
    if (s_err) err++;
    checkOutput("done_strobes", {30'd0, s_we_n, s_oe_n}, 32'd3);
  endtask

  task automatic dropReq();
    r_en = 1'b0;
    w_en = 1'b0;
    @(negedge clk); #1;
  endtask

  initial begin
    int          fz, we, oe, err;
    logic [15:0] a;
    logic [31:0] wd;

    vecs[0] = '{32'd1032,   32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 4'd3, 5, 4, 0, 0, 16'd2,      32'h0};
    vecs[1] = '{32'd1024,   32'h0,        32'h12345678, 1'b1, 1'b0, 4'd5, 5, 0, 4, 0, 16'd0,      32'h12345678};
    vecs[2] = '{32'd1036,   32'hCAFEF00D, 32'h0,        1'b0, 1'b1, 4'd1, 5, 4, 0, 0, 16'd3,      32'h12345678};
    vecs[3] = '{32'd1020,   32'h0,        32'hFFFFFFFF, 1'b1, 1'b0, 4'd2, 1, 0, 0, 1, 16'd0,      32'h0};
    vecs[4] = '{32'd263164, 32'h0,        32'hA5A55A5A, 1'b1, 1'b0, 4'd7, 5, 0, 4, 0, 16'hFFFF,   32'hA5A55A5A};
    vecs[5] = '{32'd263168, 32'h0,        32'hFFFFFFFF, 1'b1, 1'b0, 4'd8, 1, 0, 0, 1, 16'd0,      32'h0};
    vecs[6] = '{32'd1027,   32'h0,        32'h0BADF00D, 1'b1, 1'b0, 4'd9, 5, 0, 4, 0, 16'd0,      32'h0BADF00D};
    vecs[7] = '{32'd1000,   32'h11111111, 32'hFFFFFFFF, 1'b0, 1'b1, 4'd4, 1, 0, 0, 1, 16'd0,      32'h0BADF00D};
    vecs[8] = '{32'd1031,   32'h0,        32'h76543210, 1'b1, 1'b0, 4'hF, 5, 0, 4, 0, 16'd1,      32'h76543210};

    use_one = 1'b0;
    rst = 1'b0;
    alu = '0; val = '0; rdata = '0; r_en = 1'b0; w_en = 1'b0; wb_en = 1'b0; dest = '0;
    @(negedge clk); #1;
    checkOutput("reset_freeze", s_freeze, 1'b0);
    checkOutput("reset_we_n", s_we_n, 1'b1);
    checkOutput("reset_oe_n", s_oe_n, 1'b1);
    checkOutput("reset_mem", s_mem, 32'h0);
    checkOutput("reset_err", s_err, 1'b0);
    rst = 1'b1;
    @(negedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      checkOutput("pass_alu", alu4, vecs[i].alu);
      checkOutput("pass_dest", dest4, vecs[i].dest);
      checkOutput("pass_wb", wb4, vecs[i].r);
      checkOutput("pass_ren", ren4, vecs[i].r);
      measure(fz, we, oe, err, a, wd);
      checkOutput("freeze_cycles", fz, vecs[i].fz);
      checkOutput("we_cycles", we, vecs[i].we);
      checkOutput("oe_cycles", oe, vecs[i].oe);
      if (vecs[i].we + vecs[i].oe > 0) checkOutput("sram_addr", a, vecs[i].addr);
      if (vecs[i].we > 0) checkOutput("sram_wdata", wd, vecs[i].val);
      checkOutput("mem_at_done", s_mem, vecs[i].mem);
      dropReq();
      if (s_err) err++;
      checkOutput("err_pulses", err, vecs[i].err);
      checkOutput("mem_hold", s_mem, vecs[i].mem);
    end

    // Reset in the middle of a write, request kept asserted across reset.
    alu = 32'd1040; val = 32'h55AA55AA; r_en = 1'b0; w_en = 1'b1; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checkOutput("we_before_reset", s_we_n, 1'b0);
    rst = 1'b0; #1;
    checkOutput("rst_we_n", s_we_n, 1'b1);
    checkOutput("rst_freeze", s_freeze, 1'b0);
    checkOutput("rst_mem", s_mem, 32'h0);
    @(negedge clk); #1;
    checkOutput("rst_hold_freeze", s_freeze, 1'b0);
    rst = 1'b1; #1;
    measure(fz, we, oe, err, a, wd);
    checkOutput("post_rst_freeze_cycles", fz, 5);
    checkOutput("post_rst_we_cycles", we, 4);
    checkOutput("post_rst_addr", a, 16'd4);
    checkOutput("post_rst_wdata", wd, 32'h55AA55AA);
    dropReq();

    // Back-to-back load then store with no idle gap.
    alu = 32'd1024; rdata = 32'h13579BDF; r_en = 1'b1; w_en = 1'b0; #1;
    measure(fz, we, oe, err, a, wd);
    checkOutput("b2b_load_freeze", fz, 5);
    checkOutput("b2b_load_oe", oe, 4);
    checkOutput("b2b_load_mem", s_mem, 32'h13579BDF);
    alu = 32'd1044; val = 32'h2468ACE0; rdata = 32'hFFFFFFFF; r_en = 1'b0; w_en = 1'b1;
    @(negedge clk); #1;
    checkOutput("b2b_refreeze", s_freeze, 1'b1);
    measure(fz, we, oe, err, a, wd);
    checkOutput("b2b_store_freeze", fz, 5);
    checkOutput("b2b_store_we", we, 4);
    checkOutput("b2b_store_oe", oe, 0);
    checkOutput("b2b_store_addr", a, 16'd5);
    checkOutput("b2b_store_wdata", wd, 32'h2468ACE0);
    checkOutput("b2b_store_mem", s_mem, 32'h13579BDF);
    dropReq();

    // WAIT_CYCLES=1 instance: both enables means write, then a short load.
    use_one = 1'b1;
    rst = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1; #1;
    alu = 32'd1048; val = 32'h0F0F0F0F; rdata = 32'hFFFFFFFF; r_en = 1'b1; w_en = 1'b1; #1;
    measure(fz, we, oe, err, a, wd);
    checkOutput("both_freeze", fz, 2);
    checkOutput("both_we", we, 1);
    checkOutput("both_oe", oe, 0);
    checkOutput("both_addr", a, 16'd6);
    checkOutput("both_wdata", wd, 32'h0F0F0F0F);
    checkOutput("both_mem", s_mem, 32'h0);
    dropReq();
    alu = 32'd1052; rdata = 32'h0C0FFEE0; r_en = 1'b1; w_en = 1'b0; #1;
    measure(fz, we, oe, err, a, wd);
    checkOutput("w1_load_freeze", fz, 2);
    checkOutput("w1_load_oe", oe, 1);
    checkOutput("w1_load_addr", a, 16'd7);
    checkOutput("w1_load_mem", s_mem, 32'h0C0FFEE0);
    dropReq();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
Memory stage of the 5-stage ARM pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes that register's outputs.
- Translates the ALU result into a word address for an external single-port SRAM with fixed latency.
- Performs the read or write, holding the pipeline through a freeze output until the access finishes.
- Presents the MEM/WB-bound values: read data, ALU result, destination and write-back enable.

Parameters:
WAIT_CYCLES, 4, SRAM access cycles per transaction (legal range 1..15)
BASE_ADDR, 1024, byte address mapped to SRAM word 0
ADDR_W, 16, SRAM word-address width

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
ALU_res_in  in  32  byte address or ALU result from EX/MEM
Val_Rm_in  in  32  store data from EX/MEM
MEM_R_EN_in  in  1  load request
MEM_W_EN_in  in  1  store request
WB_EN_in  in  1  write-back enable from EX/MEM
Dest_in  in  4  destination register from EX/MEM
freeze  out  1  high = EX/MEM and all earlier stages hold
mem_data_out  out  32  registered load data
ALU_res_out  out  32  pass-through of ALU_res_in
WB_EN_out  out  1  pass-through of WB_EN_in
MEM_R_EN_out  out  1  pass-through of MEM_R_EN_in
Dest_out  out  4  pass-through of Dest_in
addr_err  out  1  one-cycle pulse: request address out of SRAM window
sram_addr  out  ADDR_W  SRAM word address
sram_wdata  out  32  SRAM write data
sram_rdata  in  32  SRAM read data, valid in last access cycle
sram_we_n  out  1  SRAM write strobe, active-low
sram_oe_n  out  1  SRAM output enable, active-low

Behaviour:
- States: IDLE, ACCESS, DONE. There is also a 4-bit wait counter.
- req = MEM_R_EN_in | MEM_W_EN_in. If both are set, the request is a write; the read is ignored.
- Address: off = ALU_res_in - BASE_ADDR (32-bit), word = off >> 2. off[1:0] is ignored.
- In-range means ALU_res_in >= BASE_ADDR and word < 2**ADDR_W.
- IDLE:
  - req and in-range -> ACCESS, counter = 0.
  - req and out-of-range -> DONE with no SRAM strobe, addr_err = 1 for that DONE cycle, mem_data_out = 0.
  - No req -> stay in IDLE.
- ACCESS:
  - Counter increments each cycle.
  - While counter == WAIT_CYCLES-1: for a read, capture sram_rdata into mem_data_out at the clock edge; then go to DONE.
- DONE: always -> IDLE after one cycle.
- SRAM drive:
  - sram_addr = word[ADDR_W-1:0] and sram_wdata = Val_Rm_in, held stable in ACCESS. Inputs are stable because freeze holds EX/MEM.
  - sram_we_n = 0 only in ACCESS for a write.
  - sram_oe_n = 0 only in ACCESS for a read.
  - Both are 1 otherwise.
- freeze is combinational: 1 when (IDLE and req) or ACCESS; 0 in DONE and when there is no req. freeze is forced to 0 while rst = 0.
- Stall length for an in-range access: freeze is high for exactly WAIT_CYCLES+1 cycles. It releases in DONE, so EX/MEM loads the next instruction at the end of DONE.
- Out-of-range access: freeze is high for 1 cycle (the IDLE cycle).
- Back-to-back requests: IDLE is re-entered for one cycle, and freeze rises again combinationally in that cycle.
- mem_data_out:
  - Updates only at read capture, or to 0 on an out-of-range read.
  - Holds its value across writes and idle cycles.
- Pass-through outputs are combinational copies of the inputs.
- Reset (rst = 0, asynchronous, any state including mid-ACCESS):
  - State = IDLE, counter = 0, mem_data_out = 0, addr_err = 0.
  - sram_we_n = 1, sram_oe_n = 1.
  - The aborted transaction is not retried. After reset, a still-present request starts a fresh access.
- Counter arithmetic: 4-bit. WAIT_CYCLES = 1 gives ACCESS lasting exactly one cycle.

Test Plan:
1. Reset: rst = 0 mid-ACCESS of a write -> sram_we_n = 1 immediately (before the next edge), freeze = 0, mem_data_out = 0; after rst = 1 with the request still held, a fresh access with freeze high for 5 cycles.
2. Store: WAIT_CYCLES = 4, ALU_res_in = 1032, Val_Rm_in = 0xDEADBEEF, MEM_W_EN_in = 1 -> sram_addr = 2, sram_we_n low for 4 cycles, freeze high for 5 cycles then low in DONE, mem_data_out unchanged.
3. Load: ALU_res_in = 1024, MEM_R_EN_in = 1, SRAM returns 0x12345678 -> sram_oe_n low for 4 cycles, mem_data_out = 0x12345678 in the DONE cycle and held afterwards.
4. Back-to-back: load then store with no idle gap -> each access stalls 5 cycles, freeze drops for exactly one cycle (DONE) between them, and the store uses the new address and data.
5. Out-of-range: ALU_res_in = 1020 with a read -> no strobes, addr_err pulses 1 cycle, freeze high 1 cycle, mem_data_out = 0; also ALU_res_in = 1024 + 4·65536 -> same response.
6. Both enables with WAIT_CYCLES = 1: MEM_R_EN_in = 1, MEM_W_EN_in = 1 -> write performed (sram_we_n low 1 cycle, sram_oe_n stays 1), freeze high 2 cycles.
